// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - double-buffered 8x8 LED matrix row-scan driver
module matrix_scan_driver #(
    parameter int ROW_TICKS   = 6000,
    parameter int BLANK_TICKS = 250
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [15:0] sve,
    output logic [2:0]  row_idx,
    output logic        frame_start
);

    localparam int MAXT = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    typedef enum logic {PH_BLANK = 1'b0, PH_ON = 1'b1} phase_t;

    phase_t      phase_q, phase_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]  row_q, row_d;
    logic [63:0] active_q, active_d;
    logic [63:0] pending_q, pending_d;
    logic        full_q, full_d;
    logic        init_q;
    logic [15:0] sve_q, sve_d;
    logic        start_q, start_d;
    logic        boundary;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            phase_q   <= PH_BLANK;
            tick_q    <= '0;
            row_q     <= 3'd0;
            active_q  <= 64'd0;
            pending_q <= 64'd0;
            full_q    <= 1'b0;
            init_q    <= 1'b1;
            sve_q     <= 16'h00FF;
            start_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            tick_q    <= tick_d;
            row_q     <= row_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            full_q    <= full_d;
            init_q    <= 1'b0;
            sve_q     <= sve_d;
            start_q   <= start_d;
        end
    end

    // The first edge out of reset is treated as a frame boundary, same as leaving row 7.
    always_comb begin
        phase_d   = phase_q;
        tick_d    = tick_q + 1'b1;
        row_d     = row_q;
        boundary  = 1'b0;
        active_d  = active_q;
        pending_d = pending_q;
        full_d    = full_q;
        if (init_q) begin
            tick_d   = '0;
            boundary = 1'b1;
        end else begin
            case (phase_q)
                PH_BLANK: begin
                    if (tick_q == TW'(BLANK_TICKS - 1)) begin
                        phase_d = PH_ON;
                        tick_d  = '0;
                    end
                end
                default: begin
                    if (tick_q == TW'(ROW_TICKS - 1)) begin
                        phase_d  = PH_BLANK;
                        tick_d   = '0;
                        row_d    = row_q + 3'd1;
                        boundary = (row_q == 3'd7);
                    end
                end
            endcase
        end
        if (boundary && full_q) begin
            active_d = pending_q;
            full_d   = 1'b0;
        end else if (frame_valid && !full_q) begin
            pending_d = frame_in;
            full_d    = 1'b1;
        end
    end

    // Drive word is precomputed from next state so the outputs come straight from flops.
    always_comb begin
        start_d = boundary;
        sve_d   = 16'h00FF;
        if (phase_d == PH_ON) begin
            sve_d = {8'd1 << row_d, ~active_d[{row_d, 3'b000} +: 8]};
        end
    end

    assign frame_ready = !full_q;
    assign sve         = sve_q;
    assign row_idx     = row_q;
    assign frame_start = start_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - scoreboard bench for matrix_scan_driver
module tb_matrix_scan_driver;

    localparam int R  = 4;
    localparam int B  = 2;
    localparam int RP = R + B;
    localparam int P  = 8 * RP;

    logic        clk;
    logic        rst;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] sve;
    logic [2:0]  row_idx;
    logic        frame_start;

    matrix_scan_driver #(.ROW_TICKS(R), .BLANK_TICKS(B)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .sve        (sve),
        .row_idx    (row_idx),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [20:0] exp_t;
    exp_t        exp_q[$];
    logic [63:0] pend[$];
    logic [63:0] disp;
    int          e;
    int          mp;
    int          errors;
    int          checks;
    int          cyc;

    // Reference: position within the frame is simply the edge count since reset mod P.
    always @(posedge clk) begin
        int p, row, w;
        logic [15:0] xs;
        logic [7:0]  rb;
        if (rst) begin
            pend.delete();
            disp = 64'd0;
            e    = 0;
            mp   = -1;
            exp_q.push_back({16'h00FF, 3'd0, 1'b0, 1'b1});
        end else begin
            p = e % P;
            if (p == 0 && pend.size() > 0) disp = pend.pop_front();
            else if (frame_valid && pend.size() == 0) pend.push_back(frame_in);
            row = p / RP;
            w   = p % RP;
            rb  = disp[8*row +: 8];
            xs  = (w >= B) ? {8'(1 << row), ~rb} : 16'h00FF;
            exp_q.push_back({xs, 3'(row), (p == 0), (pend.size() == 0)});
            mp = p;
            e++;
        end
    end

    always @(negedge clk) begin
        exp_t ex, ac;
        cyc++;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            ac = {sve, row_idx, frame_start, frame_ready};
            checks++;
            if (ac !== ex) begin
                errors++;
                $display("FAIL scan cyc=%0d sve=%h exp=%h row=%0d exp=%0d fs=%b exp=%b rdy=%b exp=%b",
                         cyc, ac[20:5], ex[20:5], ac[4:2], ex[4:2], ac[1], ex[1], ac[0], ex[0]);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [63:0] d);
        @(negedge clk);
        rst         = r;
        frame_valid = v;
        frame_in    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, {$urandom, $urandom});
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, {$urandom, $urandom});
    endtask

    initial begin
        bit found;
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst         = 1'b1;
        frame_valid = 1'b0;
        frame_in    = 64'd0;
        do_reset(3);

        // Diagonal frame offered on the very first cycle after reset.
        drive(1'b0, 1'b1, 64'h8040201008040201);
        idle(3 * P);

        // Sparse random writes.
        for (int i = 0; i < 8 * P; i++)
            drive(1'b0, ($urandom_range(0, 15) == 0), {$urandom, $urandom});

        // Back-to-back: valid held high with fresh data every cycle.
        for (int i = 0; i < 5 * P; i++) drive(1'b0, 1'b1, {$urandom, $urandom});

        // Reset during ON of row 5, then the display must stay dark.
        found = 1'b0;
        for (int i = 0; i < 2 * P && !found; i++) begin
            if (mp / RP == 5 && mp % RP >= B) found = 1'b1;
            else drive(1'b0, 1'b1, {$urandom, $urandom});
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL row5_wait reached=0 required=1");
        end
        do_reset(3);
        idle(2 * P + 5);

        // Double buffering: A accepted mid-frame, B offered while full must be dropped.
        idle(10);
        drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 64'd0);
        idle(2 * P);

        // Random mix including resets.
        for (int i = 0; i < 6 * P; i++) begin
            if ($urandom_range(0, 199) == 0) drive(1'b1, 1'b1, {$urandom, $urandom});
            else drive(1'b0, ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        end
        idle(4);

        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL drain left=%0d required<=1", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
